// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - state encoding and default iteration count for the multiply/divide sequencer
package multdiv_pkg;

  localparam int MULTDIV_ITERS_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } multdiv_state_t;

endpackage

// File: rtl/multdiv_iter_cnt.sv
// rtl/multdiv_iter_cnt.sv - iteration counter with load-zero, increment enable and terminal flag
module multdiv_iter_cnt
  import multdiv_pkg::*;
#(
  parameter int ITERS = MULTDIV_ITERS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     load_zero,
  input  logic                     inc_en,
  output logic [$clog2(ITERS)-1:0] count,
  output logic                     terminal
);

  localparam int CW = $clog2(ITERS);

  logic [CW-1:0] r_count;

  assign count    = r_count;
  assign terminal = (r_count == CW'(ITERS - 1));

  // Count register: cleared on clr or load, steps while enabled, holds once terminal
  always_ff @(posedge clk) begin
    if (clr || load_zero) begin
      r_count <= '0;
    end else if (inc_en && !terminal) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_sched.sv
// rtl/multdiv_sched.sv - multiply/divide sequencer FSM; MULTDIV_ZERO_BYPASS_EN lets divide-by-zero skip RUN
module multdiv_sched
  import multdiv_pkg::*;
#(
  parameter int ITERS = MULTDIV_ITERS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     ctrl_mult,
  input  logic                     ctrl_div,
  input  logic                     divisor_zero,
  output logic                     op_load_en,
  output logic                     first_step,
  output logic                     step_en,
  output logic                     is_div,
  output logic [$clog2(ITERS)-1:0] count,
  output logic                     busy,
  output logic                     stall,
  output logic                     result_rdy,
  output logic                     exception
);

  multdiv_state_t r_state;
  multdiv_state_t w_state_nxt;

  logic r_is_div;
  logic r_zero_q;
  logic w_req;
  logic w_div_req;
  logic w_accept;
  logic w_cnt_load;
  logic w_cnt_inc;
  logic w_terminal;

  // Multiply wins when both requests arrive together
  assign w_req     = ctrl_mult | ctrl_div;
  assign w_div_req = ctrl_div & ~ctrl_mult;
  assign w_accept  = (r_state == ST_IDLE) & w_req & ~clr;

  assign w_cnt_load = w_accept | (r_state == ST_DONE);
  assign w_cnt_inc  = (r_state == ST_RUN);

  assign is_div = r_is_div;

  multdiv_iter_cnt #(
    .ITERS (ITERS)
  ) u_iter_cnt (
    .clk       (clk),
    .clr       (clr),
    .load_zero (w_cnt_load),
    .inc_en    (w_cnt_inc),
    .count     (count),
    .terminal  (w_terminal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operation type and divisor-zero capture, held until the next accept
  always_ff @(posedge clk) begin
    if (clr) begin
      r_is_div <= 1'b0;
      r_zero_q <= 1'b0;
    end else if (w_accept) begin
      r_is_div <= w_div_req;
      r_zero_q <= w_div_req & divisor_zero;
    end
  end

  // Next-state and output decode; only the accept-cycle enables depend on inputs
  always_comb begin
    w_state_nxt = r_state;
    op_load_en  = 1'b0;
    first_step  = 1'b0;
    step_en     = 1'b0;
    busy        = 1'b0;
    stall       = 1'b0;
    result_rdy  = 1'b0;
    exception   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && !clr) begin
          op_load_en  = 1'b1;
          stall       = 1'b1;
          w_state_nxt = ST_RUN;
`ifdef MULTDIV_ZERO_BYPASS_EN
          if (w_div_req && divisor_zero) begin
            w_state_nxt = ST_DONE;
          end
`endif
        end
      end
      ST_RUN: begin
        step_en    = 1'b1;
        stall      = 1'b1;
        busy       = 1'b1;
        first_step = (count == '0);
        if (w_terminal) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        result_rdy  = 1'b1;
        exception   = r_is_div & r_zero_q;
        busy        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multdiv_sched.sv
// tb/tb_multdiv_sched.sv - directed table-driven bench for multdiv_sched (honours MULTDIV_ZERO_BYPASS_EN)
module tb_multdiv_sched;

  localparam int ITERS = 32;
  localparam int CW    = $clog2(ITERS);

  logic          clk = 1'b0;
  logic          clr;
  logic          ctrl_mult;
  logic          ctrl_div;
  logic          divisor_zero;
  logic          op_load_en;
  logic          first_step;
  logic          step_en;
  logic          is_div;
  logic [CW-1:0] count;
  logic          busy;
  logic          stall;
  logic          result_rdy;
  logic          exception;

  int checks   = 0;
  int failures = 0;
  logic m_is_div = 1'b0;

  typedef struct {
    string name;
    logic  mult;
    logic  div;
    logic  dz;
    logic  exp_is_div;
    logic  exp_exc;
    int    rdy;
  } vec_t;

  vec_t vecs[5];

  multdiv_sched #(.ITERS(ITERS)) dut (
    .clk          (clk),
    .clr          (clr),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .divisor_zero (divisor_zero),
    .op_load_en   (op_load_en),
    .first_step   (first_step),
    .step_en      (step_en),
    .is_div       (is_div),
    .count        (count),
    .busy         (busy),
    .stall        (stall),
    .result_rdy   (result_rdy),
    .exception    (exception)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string p, input logic ld, input logic fs, input logic se,
                           input logic isd, input int cnt, input logic bsy, input logic stl,
                           input logic rdy, input logic exc);
    chk({p, ".op_load_en"}, 32'(op_load_en), 32'(ld));
    chk({p, ".first_step"}, 32'(first_step), 32'(fs));
    chk({p, ".step_en"},    32'(step_en),    32'(se));
    chk({p, ".is_div"},     32'(is_div),     32'(isd));
    chk({p, ".count"},      32'(count),      32'(cnt));
    chk({p, ".busy"},       32'(busy),       32'(bsy));
    chk({p, ".stall"},      32'(stall),      32'(stl));
    chk({p, ".result_rdy"}, 32'(result_rdy), 32'(rdy));
    chk({p, ".exception"},  32'(exception),  32'(exc));
  endtask

  task automatic drive(input logic c, input logic m, input logic d, input logic z);
    clr = c; ctrl_mult = m; ctrl_div = d; divisor_zero = z;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    int  rdy = v.rdy;
    bit  e_run, e_done;
    int  e_cnt;
    for (int c = 0; c <= rdy + 1; c++) begin
      if (c == 0) drive(1'b0, v.mult, v.div, v.dz);
      else        drive(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (c > 0) m_is_div = v.exp_is_div;
      e_run  = (c >= 1) && (c < rdy);
      e_done = (c == rdy);
      e_cnt  = e_run ? (c - 1) : (e_done ? ((rdy == 1) ? 0 : ITERS - 1) : 0);
      check_all($sformatf("%s.c%0d", v.name, c), c == 0, e_run && (c == 1), e_run, m_is_div,
                e_cnt, e_run || e_done, (c == 0) || e_run, e_done, e_done && v.exp_exc);
      next_cycle();
    end
  endtask

  initial begin
    int n_rdy;
    vecs[0] = '{"mul",       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ITERS + 1};
    vecs[1] = '{"div",       1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ITERS + 1};
`ifdef MULTDIV_ZERO_BYPASS_EN
    vecs[2] = '{"div_zero",  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
`else
    vecs[2] = '{"div_zero",  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, ITERS + 1};
`endif
    vecs[3] = '{"both_zero", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ITERS + 1};
    vecs[4] = '{"mul_zero",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ITERS + 1};

    // Reset held two cycles with a multiply request present
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    @(negedge clk);
    check_all("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    check_all("rst2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_all("rst_rel", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i]);
    end

    // Requests during RUN and DONE are ignored; next request right after DONE is taken
    n_rdy = 0;
    for (int c = 0; c <= 34; c++) begin
      drive(1'b0, c == 0 || c == 34, c == 5 || c == 33, c == 5 || c == 33);
      @(negedge clk);
      if (result_rdy) n_rdy++;
      if (c == 5) begin
        chk("ign.c5.op_load_en", 32'(op_load_en), 0);
        chk("ign.c5.stall", 32'(stall), 1);
      end
      if (c == 33) begin
        chk("ign.c33.result_rdy", 32'(result_rdy), 1);
        chk("ign.c33.op_load_en", 32'(op_load_en), 0);
        chk("ign.c33.is_div", 32'(is_div), 0);
        chk("ign.c33.exception", 32'(exception), 0);
        chk("ign.c33.stall", 32'(stall), 0);
      end
      if (c == 34) begin
        chk("ign.c34.op_load_en", 32'(op_load_en), 1);
        chk("ign.c34.stall", 32'(stall), 1);
      end
      next_cycle();
    end
    chk("ign.rdy_pulses", 32'(n_rdy), 2'd1);
    n_rdy = 0;
    for (int c = 35; c <= 68; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (result_rdy) n_rdy++;
      if (c == 35) chk("ign2.c35.first_step", 32'(first_step), 1);
      if (c == 67) chk("ign2.c67.result_rdy", 32'(result_rdy), 1);
      next_cycle();
    end
    chk("ign2.rdy_pulses", 32'(n_rdy), 1);
    m_is_div = 1'b0;

    // clr in the middle of a divide aborts it with no result
    n_rdy = 0;
    for (int c = 0; c <= 40; c++) begin
      drive(c == 10, 1'b0, c == 0, 1'b0);
      @(negedge clk);
      if (result_rdy) n_rdy++;
      if (c == 10) chk("clr.c10.busy", 32'(busy), 1);
      if (c == 11) check_all("clr.c11", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
    end
    chk("clr.rdy_pulses", 32'(n_rdy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
